// File: rtl/traffic_pkg.sv
// Shared types for the demand-driven traffic light:
// controller states and one-hot lamp encodings.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED,
    GREEN,
    YELLOW,
    EMERG
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  function automatic logic [2:0] state_lights(
    input state_t s
  );
    logic [2:0] l;
    l = LIGHT_RED;
    case (s)
      GREEN:   l = LIGHT_GREEN;
      YELLOW:  l = LIGHT_YELLOW;
      default: l = LIGHT_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/queue_counter.sv
// 4-bit saturating up/down counter of vehicles
// waiting at the stop line.
module queue_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] count_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && count_q != 4'hF)
      count_d = count_q + 4'd1;
    else if (dec_i && !inc_i && count_q != 4'h0)
      count_d = count_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 4'h0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/smart_traffic_light.sv
// Single-approach traffic light: RED/GREEN/YELLOW
// sequencing on demand, with emergency preemption.
module smart_traffic_light
  import traffic_pkg::*;
#(
  parameter int RED_CYCLES    = 4,
  parameter int GREEN_CYCLES  = 6,
  parameter int YELLOW_CYCLES = 2,
  parameter int TIMER_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_detected,
  input  logic       emergency,
  output logic [2:0] lights,
  output logic [3:0] queue_count
);

  localparam logic [TIMER_W-1:0] RED_T =
    TIMER_W'(RED_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GRN_T =
    TIMER_W'(GREEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] YEL_T =
    TIMER_W'(YELLOW_CYCLES - 1);

  state_t             state_q;
  state_t             state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic [2:0]         lights_q;
  logic               demand;
  logic               depart;

  assign demand = (queue_count != 4'h0)
                | car_detected;
  assign depart = (state_q == GREEN)
                & (queue_count != 4'h0);

  // Emergency wins over every timed transition.
  always_comb begin
    state_d = state_q;
    if (emergency) begin
      state_d = EMERG;
    end else begin
      case (state_q)
        RED:
          if (timer_q >= RED_T && demand)
            state_d = GREEN;
        GREEN:
          if (timer_q == GRN_T)
            state_d = YELLOW;
        YELLOW:
          if (timer_q == YEL_T)
            state_d = RED;
        EMERG:
          state_d = RED;
        default:
          state_d = RED;
      endcase
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)
      timer_d = '0;
    else if (timer_q != '1)
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RED;
      timer_q  <= '0;
      lights_q <= LIGHT_RED;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      lights_q <= state_lights(state_d);
    end
  end

  assign lights = lights_q;

  queue_counter u_queue (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (car_detected),
    .dec_i   (depart),
    .count_o (queue_count)
  );

endmodule

// File: tb/tb_smart_traffic_light.sv
// Directed bench for smart_traffic_light with
// hand-computed lamp and queue expectations.
module tb_smart_traffic_light;

  localparam int R = 4;
  localparam int Y = 2;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       car_detected = 1'b0;
  logic       emergency = 1'b0;
  logic [2:0] lights;
  logic [3:0] queue_count;

  int total = 0;
  int bad = 0;

  int nl [16] = '{R, R, R, G, G, G, G, G,
                  G, Y, Y, R, R, R, R, G};
  int nq [16] = '{1, 2, 3, 4, 4, 4, 4, 4,
                  4, 4, 5, 6, 7, 8, 9, 10};

  always #5 clk = ~clk;

  smart_traffic_light dut (
    .clk          (clk),
    .rst          (rst),
    .car_detected (car_detected),
    .emergency    (emergency),
    .lights       (lights),
    .queue_count  (queue_count)
  );

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic check_st(
    input string tag,
    input int    el,
    input int    eq
  );
    check({tag, "_lights"}, 8'(lights), 8'(el));
    check({tag, "_queue"}, 8'(queue_count), 8'(eq));
  endtask

  task automatic step(input logic c, input logic e);
    car_detected = c;
    emergency = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    car_detected = 1'b0;
    emergency = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 check_st("rst_async0", R, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_st("rst_hold", R, 0);
    rst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0);
      check_st($sformatf("idle%0d", i), R, 0);
    end

    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0);
      check_st($sformatf("norm%0d", i),
               nl[i-1], nq[i-1]);
    end
    for (int i = 17; i <= 24; i++) begin
      step(1'b0, i <= 19);
      check_st($sformatf("emerg%0d", i),
               (i == 24) ? G : R, 9);
    end

    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1);
      check_st($sformatf("fill%0d", i), R, i);
    end
    for (int i = 6; i <= 25; i++) begin
      step(1'b0, 1'b0);
      check_st($sformatf("drain%0d", i),
               (i <= 9)  ? R :
               (i <= 15) ? G :
               (i <= 17) ? Y : R,
               (i <= 10) ? 5 :
               (i <= 15) ? 15 - i : 0);
    end

    do_reset();
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1);
      check_st($sformatf("sat%0d", i), R,
               (i > 15) ? 15 : i);
    end
    for (int i = 21; i <= 31; i++) begin
      step(1'b0, 1'b0);
      check_st($sformatf("satrel%0d", i),
               (i <= 24) ? R :
               (i <= 30) ? G : Y,
               (i <= 25) ? 15 : 40 - i);
    end
    #3 rst = 1'b0;
    #1 check_st("rst_mid_yellow", R, 0);
    #1 rst = 1'b1;

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
